// File: rtl/serdesphy_rx_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : serdesphy_rx_word_unpacker
// Description : Buffers received words in a small FIFO and serialises each
//               word into N lanes of LANE_W bits with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serdesphy_rx_word_unpacker #(
    parameter int WORD_W     = 8,
    parameter int LANE_W     = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int MSB_FIRST  = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [WORD_W-1:0]                  in_word,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [LANE_W-1:0]                  out_lane,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_first,
    output logic                               out_last,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic [7:0]                         drop_count
);

    localparam int N     = WORD_W / LANE_W;
    localparam int IDX_W = $clog2(N);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);
    localparam logic [LVL_W-1:0] c_full_lvl = LVL_W'(FIFO_DEPTH);

    localparam logic [0:0] c_st_empty  = 1'b0;
    localparam logic [0:0] c_st_active = 1'b1;

    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [0:0]        r_state;
    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_drop;

    logic              w_active;
    logic              w_push;
    logic              w_pop;
    logic              w_xfer;
    logic              w_at_last;
    logic              w_fifo_empty;
    logic [LANE_W-1:0] w_lanes [N];

    assign w_active     = (r_state == c_st_active);
    assign w_fifo_empty = (r_level == '0);
    assign w_at_last    = (r_idx == c_last_idx);
    assign w_xfer       = w_active && out_ready;
    // Full means full: a pop in the same cycle does not open a slot early.
    assign in_ready     = (r_level != c_full_lvl);
    assign w_push       = in_valid && in_ready;
    assign w_pop        = (!w_active || (w_xfer && w_at_last)) && !w_fifo_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_empty;
            r_word  <= '0;
            r_idx   <= '0;
        end else if (w_pop) begin
            r_state <= c_st_active;
            r_word  <= r_mem[r_rd_ptr];
            r_idx   <= '0;
        end else if (w_xfer) begin
            if (w_at_last) begin
                r_state <= c_st_empty;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= '0;
        end else if (in_valid && !in_ready && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    // Lane k of the word, in transmit order.
    generate
        for (genvar k = 0; k < N; k++) begin : g_lane
            if (MSB_FIRST != 0) begin : g_msb
                assign w_lanes[k] = r_word[(N-1-k)*LANE_W +: LANE_W];
            end else begin : g_lsb
                assign w_lanes[k] = r_word[k*LANE_W +: LANE_W];
            end
        end
    endgenerate

    assign out_valid  = w_active;
    assign out_lane   = w_active ? w_lanes[r_idx] : '0;
    assign out_first  = w_active && (r_idx == '0);
    assign out_last   = w_active && w_at_last;
    assign fifo_level = r_level;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_serdesphy_rx_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_serdesphy_rx_word_unpacker
// Description : Self-checking bench; queue-based reference model plus
//               directed scenarios and a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serdesphy_rx_word_unpacker;

    localparam int WORD_W = 8;
    localparam int LANE_W = 4;
    localparam int DEPTH  = 2;
    localparam int N      = WORD_W / LANE_W;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [WORD_W-1:0] in_word = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [LANE_W-1:0] out_lane;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_first;
    logic              out_last;
    logic [LVL_W-1:0]  fifo_level;
    logic [7:0]        drop_count;

    logic [15:0] m_in_word = '0;
    logic        m_in_valid = 1'b0;
    logic        m_in_ready;
    logic [3:0]  m_out_lane;
    logic        m_out_valid;
    logic        m_out_first;
    logic        m_out_last;
    logic [2:0]  m_fifo_level;
    logic [7:0]  m_drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    int mq[$];
    bit mv = 0;
    int mword = 0;
    int midx = 0;
    int mdrop = 0;

    int obs[$];
    int m_obs[$];

    serdesphy_rx_word_unpacker #(
        .WORD_W(WORD_W), .LANE_W(LANE_W), .FIFO_DEPTH(DEPTH), .MSB_FIRST(0)
    ) dut (
        .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
        .in_ready(in_ready), .out_lane(out_lane), .out_valid(out_valid),
        .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
        .fifo_level(fifo_level), .drop_count(drop_count)
    );

    serdesphy_rx_word_unpacker #(
        .WORD_W(16), .LANE_W(4), .FIFO_DEPTH(4), .MSB_FIRST(1)
    ) dut_m (
        .clk(clk), .rst(rst), .in_word(m_in_word), .in_valid(m_in_valid),
        .in_ready(m_in_ready), .out_lane(m_out_lane), .out_valid(m_out_valid),
        .out_ready(1'b1), .out_first(m_out_first), .out_last(m_out_last),
        .fifo_level(m_fifo_level), .drop_count(m_drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lane_of(input int w, input int k);
        return (w / (1 << (k * LANE_W))) % (1 << LANE_W);
    endfunction

    // Reference behaviour for one rising edge, from the current inputs.
    task automatic model_edge();
        bit xfer;
        bit lastl;
        bit room;
        bit pop;
        if (rst) begin
            mq.delete();
            mv = 0; midx = 0; mdrop = 0;
        end else begin
            xfer  = mv && out_ready;
            lastl = (midx == N - 1);
            room  = (mq.size() < DEPTH);
            pop   = (!mv || (xfer && lastl)) && (mq.size() > 0);
            if (in_valid && !room && mdrop < 255) mdrop++;
            if (pop) begin
                mword = mq.pop_front();
                midx = 0;
                mv = 1;
            end else if (xfer) begin
                if (lastl) mv = 0;
                else midx++;
            end
            if (in_valid && room) mq.push_back(int'(in_word));
        end
    endtask

    task automatic compare_all();
        check_val("out_valid",  32'(out_valid),  32'(mv));
        check_val("out_lane",   32'(out_lane),   mv ? lane_of(mword, midx) : 0);
        check_val("out_first",  32'(out_first),  32'(mv && midx == 0));
        check_val("out_last",   32'(out_last),   32'(mv && midx == N - 1));
        check_val("fifo_level", 32'(fifo_level), mq.size());
        check_val("in_ready",   32'(in_ready),   32'(mq.size() != DEPTH));
        check_val("drop_count", 32'(drop_count), mdrop);
    endtask

    task automatic step();
        if (out_valid && out_ready) obs.push_back(int'(out_lane));
        if (m_out_valid) m_obs.push_back({m_out_first, m_out_last, m_out_lane});
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step(); step();
        check_val("rst_valid", 32'(out_valid), 0);
        check_val("rst_lane", 32'(out_lane), 0);
        rst = 1'b0;
        step();
        check_val("rst_in_ready", 32'(in_ready), 1);

        // Single word, LSB lane first, with first-edge latency
        obs.delete();
        out_ready = 1'b1;
        in_word = 8'hA5; in_valid = 1'b1;
        step();
        check_val("lat_E", 32'(out_valid), 0);
        in_valid = 1'b0;
        step();
        check_val("lat_E1", 32'(out_valid), 1);
        check_val("lat_first", 32'(out_first), 1);
        repeat (4) step();
        check_val("a5_n", obs.size(), 2);
        if (obs.size() == 2) begin
            check_val("a5_l0", obs[0], 32'h5);
            check_val("a5_l1", obs[1], 32'hA);
        end
        check_val("a5_idle", 32'(out_valid), 0);

        // MSB-first 16-bit instance
        m_obs.delete();
        m_in_word = 16'h1234; m_in_valid = 1'b1;
        step();
        m_in_valid = 1'b0;
        repeat (7) step();
        check_val("msb_n", m_obs.size(), 4);
        if (m_obs.size() == 4) begin
            check_val("msb_l0", m_obs[0], 32'h21);
            check_val("msb_l1", m_obs[1], 32'h02);
            check_val("msb_l2", m_obs[2], 32'h03);
            check_val("msb_l3", m_obs[3], 32'h14);
        end

        // Back-to-back words stream without bubbles
        obs.delete();
        in_valid = 1'b1;
        in_word = 8'h12; step();
        in_word = 8'h34; step();
        in_word = 8'h56; step();
        in_valid = 1'b0;
        repeat (5) step();
        check_val("b2b_n", obs.size(), 6);
        if (obs.size() == 6) begin
            check_val("b2b_l0", obs[0], 2); check_val("b2b_l1", obs[1], 1);
            check_val("b2b_l2", obs[2], 4); check_val("b2b_l3", obs[3], 3);
            check_val("b2b_l4", obs[4], 6); check_val("b2b_l5", obs[5], 5);
        end
        check_val("b2b_drop", 32'(drop_count), 0);
        repeat (2) step();

        // Blocked output: fill stage + FIFO, one drop, lane held
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_word = 8'(8'h31 + i * 8'h11);
            step();
        end
        in_valid = 1'b0;
        check_val("blk_level", 32'(fifo_level), 2);
        check_val("blk_in_ready", 32'(in_ready), 0);
        check_val("blk_drop", 32'(drop_count), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("blk_hold", 32'(out_lane), 32'h1);
        end
        out_ready = 1'b1;
        repeat (8) step();

        // Reset mid-word
        rst = 1'b1; step(); rst = 1'b0;
        in_word = 8'hC3; in_valid = 1'b1; step();
        in_valid = 1'b0; step();
        step();
        check_val("mid_lane1", 32'(out_lane), 32'hC);
        rst = 1'b1; step(); rst = 1'b0;
        check_val("mid_valid", 32'(out_valid), 0);
        check_val("mid_level", 32'(fifo_level), 0);
        check_val("mid_drop", 32'(drop_count), 0);
        obs.delete();
        in_word = 8'h7E; in_valid = 1'b1; step();
        in_valid = 1'b0;
        repeat (4) step();
        check_val("mid_n", obs.size(), 2);
        if (obs.size() == 2) begin
            check_val("mid_l0", obs[0], 32'hE);
            check_val("mid_l1", obs[1], 32'h7);
        end

        // Drop counter saturation
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_word = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        check_val("sat_drop", 32'(drop_count), 255);
        step();
        rst = 1'b1; step(); rst = 1'b0;

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            in_word   = 8'($urandom);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serdesphy_rx_word_unpacker.md
SERDESPHY_RX_WORD_UNPACKER -- requirements
Module: serdesphy_rx_word_unpacker

Interface
REQ-001 SHALL have parameter WORD_W, default 8, received word width in bits.
REQ-002 SHALL have parameter LANE_W, default 4, output lane width in bits; WORD_W SHALL be an integer multiple of LANE_W, with ratio N = WORD_W/LANE_W >= 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, input word FIFO entries; power of two, >= 2.
REQ-004 SHALL have parameter MSB_FIRST, default 0; 0 = least-significant lane first, 1 = most-significant lane first.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_word  input  WORD_W  received word.
REQ-008 in_valid  input  1  in_word valid this cycle.
REQ-009 in_ready  output  1  FIFO can accept a word this cycle.
REQ-010 out_lane  output  LANE_W  current output lane.
REQ-011 out_valid  output  1  out_lane valid.
REQ-012 out_ready  input  1  downstream accepts out_lane this cycle.
REQ-013 out_first / out_last  output  1 each  current lane is the first / last lane of its word.
REQ-014 fifo_level  output  clog2(FIFO_DEPTH+1)  words held in FIFO (excludes output stage).
REQ-015 drop_count  output  8  saturating count of words offered while in_ready=0.

Function
REQ-016 Input accept SHALL occur at a rising edge where in_valid=1 and in_ready=1; the word is written at the FIFO tail.
REQ-017 in_ready SHALL equal (fifo_level != FIFO_DEPTH), with no same-cycle pass-through when full, even if the FIFO is read that cycle.
REQ-018 At an edge with in_valid=1 and in_ready=0, the word SHALL be discarded and drop_count SHALL increment, saturating at 255.
REQ-019 Output stage SHALL hold one word plus a lane index 0..N-1; states are EMPTY (out_valid=0) and ACTIVE (out_valid=1).
REQ-020 Lane transfer SHALL occur at an edge where out_valid=1 and out_ready=1.
REQ-021 While out_valid=1 and out_ready=0, out_lane, out_first and out_last SHALL hold stable.
REQ-022 Lane k SHALL be in_word[k*LANE_W +: LANE_W] when MSB_FIRST=0, and in_word[(N-1-k)*LANE_W +: LANE_W] when MSB_FIRST=1.
REQ-023 out_first SHALL be 1 at index 0; out_last SHALL be 1 at index N-1.
REQ-024 Stage load SHALL occur when the stage is EMPTY, or a last-lane transfer occurs, and the FIFO is non-empty; it pops the FIFO head and sets index 0.
REQ-025 Back-to-back words SHALL stream without bubbles: after a last-lane transfer with the FIFO non-empty, the next cycle presents lane 0 of the next word.
REQ-026 A last-lane transfer with the FIFO empty SHALL return the stage to EMPTY.
REQ-027 A non-last transfer SHALL increment the index by 1.
REQ-028 Latency SHALL be: a word accepted at edge E into an empty FIFO and empty stage is loaded at edge E+1; out_valid=1 from E+1.
REQ-029 A simultaneous FIFO write and pop SHALL leave fifo_level unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 Reset SHALL, at any time including mid-word, discard the FIFO and stage contents, clear drop_count, and set fifo_level=0.
REQ-031 Reset SHALL take the stage to EMPTY with out_valid=0, out_first=0, out_last=0 and out_lane=0.
REQ-032 in_ready SHALL read 1 in the first cycle after reset deasserts.
REQ-033 During reset, in_valid SHALL be ignored and not counted as a drop.

Verification
REQ-034 Defaults, out_ready=1, single word 0xA5 -> out_valid from E+1; lanes 0x5 (first=1), 0xA (last=1); then out_valid=0.
REQ-035 MSB_FIRST=1, WORD_W=16, LANE_W=4, word 0x1234 -> lanes 0x1,0x2,0x3,0x4 with first/last on the ends.
REQ-036 out_ready=1, words 0x12,0x34,0x56 on consecutive cycles -> lane stream 2,1,4,3,6,5 with no gap after the first lane; drop_count=0.
REQ-037 out_ready=0 held; offer 4 words -> 1 loaded to stage, 2 in FIFO (fifo_level=2, in_ready=0), 1 dropped (drop_count=1); out_lane stable throughout.
REQ-038 Assert rst after lane 0 of 0xC3 -> out_valid=0, fifo_level=0, drop_count=0 next cycle; a new word 0x7E then yields 0xE,0x7.
REQ-039 Offer 300 words while blocked -> drop_count saturates at 255.
